// File: rtl/half_adder.sv
// ============================================================================
// Module      : half_adder
// Description : Lane-wise half adder with combinational and registered outputs.
//               Optional carry-event counter enabled by HALF_ADDER_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module half_adder #(
    parameter int WIDTH = 1
`ifdef HALF_ADDER_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid
`ifdef HALF_ADDER_CNT_EN
    ,
    output logic [CNT_W-1:0] carry_cnt
`endif
);

    // Each lane is built separately so an X on one lane stays in that lane.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign sum[i] = a[i] ^ b[i];
        assign c[i]   = a[i] & b[i];
    end

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] c_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] sum_q_r;
    logic [WIDTH-1:0] c_q_r;
    logic             out_valid_q;

    always_comb begin
        sum_d       = sum_q_r;
        c_d         = c_q_r;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sum_d       = sum;
            c_d         = c;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q_r     <= '0;
            c_q_r       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sum_q_r     <= sum_d;
            c_q_r       <= c_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign sum_q     = sum_q_r;
    assign c_q       = c_q_r;
    assign out_valid = out_valid_q;

`ifdef HALF_ADDER_CNT_EN
    logic [CNT_W-1:0] carry_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q;

    // Saturating: once all ones, further carry events are ignored.
    always_comb begin
        carry_cnt_d = carry_cnt_q;
        if (in_valid && (|c) && (carry_cnt_q != {CNT_W{1'b1}})) begin
            carry_cnt_d = carry_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt_q <= '0;
        end else begin
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign carry_cnt = carry_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_half_adder.sv
// ============================================================================
// Module      : tb_half_adder
// Description : Self-checking bench for half_adder (WIDTH=1 and WIDTH=4 copies).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_half_adder;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic [3:0] a4 = '0, b4 = '0;

    logic [0:0] sum1, c1, sum_q1, c_q1;
    logic [3:0] sum4, c4, sum_q4, c_q4;
    logic       ov1, ov4;
`ifdef HALF_ADDER_CNT_EN
    logic [15:0] cnt1;
    logic [1:0]  cnt4;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] s;
        logic [3:0] c;
    } exp_t;
    exp_t sb[$];

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    half_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid),
        .sum(sum1), .c(c1), .sum_q(sum_q1), .c_q(c_q1), .out_valid(ov1)
`ifdef HALF_ADDER_CNT_EN
        , .carry_cnt(cnt1)
`endif
    );

    half_adder #(
        .WIDTH(4)
`ifdef HALF_ADDER_CNT_EN
        , .CNT_W(2)
`endif
    ) u_dut4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid),
        .sum(sum4), .c(c4), .sum_q(sum_q4), .c_q(c_q4), .out_valid(ov4)
`ifdef HALF_ADDER_CNT_EN
        , .carry_cnt(cnt4)
`endif
    );

    // Reference: per-lane arithmetic add, split into carry and sum bits.
    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        logic [1:0] t;
        for (int i = 0; i < 4; i++) begin
            t = {1'b0, x[i]} + {1'b0, y[i]};
            e.s[i] = t[0];
            e.c[i] = t[1];
        end
        return e;
    endfunction

    task automatic test_comb_no_clock();
        logic [1:0] pat [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [1:0] exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            {a1, b1} = pat[i];
            #5;
            checks++;
            if ({sum1, c1} !== exp[i]) begin
                errors++;
                $display("FAIL comb_tt[%0d] got sum,c=%b expected %b", i, {sum1, c1}, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        #1;
        checks++;
        if ({sum1, c1} !== 2'b01) begin
            errors++;
            $display("FAIL reset_comb got sum,c=%b expected 01", {sum1, c1});
        end
        checks++;
        if ({sum_q1, c_q1, ov1, sum_q4, c_q4, ov4} !== 11'b0) begin
            errors++;
            $display("FAIL reset_regs got %b expected all zero",
                     {sum_q1, c_q1, ov1, sum_q4, c_q4, ov4});
        end
    endtask

    task automatic test_registered();
        clk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        a1 = 1'b1; b1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({sum_q1, c_q1, ov1} !== 3'b101) begin
            errors++;
            $display("FAIL reg_capture got sum_q,c_q,ov=%b expected 101", {sum_q1, c_q1, ov1});
        end
        @(negedge clk);
        in_valid = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({sum_q1, c_q1, ov1} !== 3'b100) begin
            errors++;
            $display("FAIL reg_hold got sum_q,c_q,ov=%b expected 100", {sum_q1, c_q1, ov1});
        end
    endtask

    task automatic test_wide();
        exp_t e;
        @(negedge clk);
        a4 = 4'b1100; b4 = 4'b1010;
        in_valid = 1'b1;
        sb.push_back(model(a4, b4));
        #1;
        checks++;
        if (sum4 !== 4'b0110 || c4 !== 4'b1000) begin
            errors++;
            $display("FAIL wide_comb got sum=%b c=%b expected 0110 1000", sum4, c4);
        end
        @(posedge clk); #1;
        e = sb.pop_front();
        checks++;
        if (sum_q4 !== e.s || c_q4 !== e.c || ov4 !== 1'b1) begin
            errors++;
            $display("FAIL wide_reg got sum_q=%b c_q=%b ov=%b expected %b %b 1",
                     sum_q4, c_q4, ov4, e.s, e.c);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        exp_t last;
        last = '{s: sum_q4, c: c_q4};
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            a4 = 4'($urandom);
            b4 = 4'($urandom);
            in_valid = (k % 4 != 3);
            if (in_valid) sb.push_back(model(a4, b4));
            @(posedge clk); #1;
            if (k % 4 != 3) begin
                e = sb.pop_front();
                last = e;
            end else begin
                e = last;
            end
            checks++;
            if (sum_q4 !== e.s || c_q4 !== e.c || ov4 !== (k % 4 != 3)) begin
                errors++;
                $display("FAIL b2b[%0d] got sum_q=%b c_q=%b ov=%b expected %b %b %b",
                         k, sum_q4, c_q4, ov4, e.s, e.c, (k % 4 != 3));
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        a4 = 4'b0111; b4 = 4'b0101;
        in_valid = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ov4 !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_valid got ov=%b expected 1", ov4);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sum_q4, c_q4, ov4, sum_q1, c_q1, ov1} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset got %b expected all zero",
                     {sum_q4, c_q4, ov4, sum_q1, c_q1, ov1});
        end
        e = model(a4, b4);
        checks++;
        if (sum4 !== e.s || c4 !== e.c) begin
            errors++;
            $display("FAIL reset_comb_wide got sum=%b c=%b expected %b %b", sum4, c4, e.s, e.c);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'b1111; b4 = 4'b0001;
        e = model(a4, b4);
        @(posedge clk); #1;
        checks++;
        if (sum_q4 !== e.s || c_q4 !== e.c || ov4 !== 1'b1) begin
            errors++;
            $display("FAIL first_capture got sum_q=%b c_q=%b ov=%b expected %b %b 1",
                     sum_q4, c_q4, ov4, e.s, e.c);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

`ifdef HALF_ADDER_CNT_EN
    task automatic test_counter();
        logic [1:0] exp_cnt;
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (cnt4 !== 2'd0) begin
            errors++;
            $display("FAIL cnt_reset got %0d expected 0", cnt4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'b0001; b4 = 4'b0001;
        exp_cnt = 2'd0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
            @(posedge clk); #1;
            checks++;
            if (cnt4 !== exp_cnt) begin
                errors++;
                $display("FAIL cnt_sat[%0d] got %0d expected %0d", k, cnt4, exp_cnt);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_comb_no_clock();
        test_reset();
        test_registered();
        test_wide();
        test_back_to_back();
        test_async_reset();
`ifdef HALF_ADDER_CNT_EN
        test_counter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
